// File: rtl/register_file_read_sequencer_pkg.sv
// Shared constants and FSM encoding for the register-file read sequencer.
// The write-address mux and the register file import the same definitions.
package register_file_read_sequencer_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;

  // Operand B is forced to the stack pointer register when RFRA=1.
  localparam logic [3:0] SP_REG = 4'hD;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE_A = 3'd1,
    ST_ISSUE_B = 3'd2,
    ST_CAPT_B  = 3'd3,
    ST_HOLD    = 3'd4
  } state_t;

  function automatic logic [3:0] sel_addr_b(input logic [7:0] ir, input logic rfra);
    return rfra ? SP_REG : ir[3:0];
  endfunction

endpackage

// File: rtl/register_file_read_sequencer_if.sv
// Bus between the operand-fetch sequencer, the register file and the ALU.
// Valid/Ready: Valid rises only in HOLD with operands frozen; a transfer completes on
// the first rising edge where Valid=1 and Ready=1. Ready while Valid=0 is ignored.
interface register_file_read_sequencer_if #(
  parameter int DATA_W = register_file_read_sequencer_pkg::DATA_W,
  parameter int ADDR_W = register_file_read_sequencer_pkg::ADDR_W
);
  import register_file_read_sequencer_pkg::*;

  logic              Start;
  logic              RFRA;
  logic [7:0]        InstructionRegister;
  logic [ADDR_W-1:0] RegReadAddr;
  logic [DATA_W-1:0] RegReadData;
  logic              WriteEnable;
  logic [ADDR_W-1:0] WriteAddr;
  logic [DATA_W-1:0] WriteData;
  logic [DATA_W-1:0] OperandA;
  logic [DATA_W-1:0] OperandB;
  logic              Valid;
  logic              Ready;
  logic              Busy;
  state_t            state_dbg;

  modport master (
    output Start, RFRA, InstructionRegister, RegReadData,
           WriteEnable, WriteAddr, WriteData, Ready,
    input  RegReadAddr, OperandA, OperandB, Valid, Busy, state_dbg
  );

  modport slave (
    input  Start, RFRA, InstructionRegister, RegReadData,
           WriteEnable, WriteAddr, WriteData, Ready,
    output RegReadAddr, OperandA, OperandB, Valid, Busy, state_dbg
  );

endinterface

// File: rtl/register_file_read_sequencer_bypass.sv
// One operand's forwarding slot: snoops the write port during its ISSUE cycle and
// substitutes the written value for the (stale) register-file read data at capture.
module operand_bypass_slot #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              snoop,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] capt_data
);

  logic [DATA_W-1:0] byp_data;
  logic              byp_flag;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      byp_data <= '0;
      byp_flag <= 1'b0;
    end else if (clear) begin
      byp_data <= '0;
      byp_flag <= 1'b0;
    end else if (snoop && we && (wa == addr)) begin
      // The register file returns old data on read-during-write, so keep the new value here.
      byp_data <= wd;
      byp_flag <= 1'b1;
    end
  end

  assign capt_data = byp_flag ? byp_data : rd_data;

endmodule

// File: rtl/register_file_read_sequencer.sv
// Fetches operands A and B through the single synchronous read port, forwarding
// same-cycle writes, and holds them for the ALU until accepted.
module register_file_read_sequencer
  import register_file_read_sequencer_pkg::*;
#(
  parameter int DATA_W = register_file_read_sequencer_pkg::DATA_W,
  parameter int ADDR_W = register_file_read_sequencer_pkg::ADDR_W
) (
  input logic CLK,
  input logic Reset,
  register_file_read_sequencer_if.slave bus
);

  state_t            state, state_nx;
  logic [ADDR_W-1:0] addr_a, addr_b;
  logic [ADDR_W-1:0] addr_a_d, addr_b_d;
  logic              latch_req, issue_a, issue_b, capt_a, capt_b;
  logic              clear_byp;
  logic [DATA_W-1:0] capt_a_data, capt_b_data;

  assign addr_a_d = ADDR_W'(bus.InstructionRegister[7:4]);
  assign addr_b_d = ADDR_W'(sel_addr_b(bus.InstructionRegister, bus.RFRA));

  always_ff @(posedge CLK) begin
    if (!Reset) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    latch_req = 1'b0;
    issue_a   = 1'b0;
    issue_b   = 1'b0;
    capt_a    = 1'b0;
    capt_b    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.Start) begin
          latch_req = 1'b1;
          state_nx  = ST_ISSUE_A;
        end
      end
      ST_ISSUE_A: begin
        issue_a  = 1'b1;
        state_nx = ST_ISSUE_B;
      end
      ST_ISSUE_B: begin
        // Read data for A arrives this cycle while B's address goes out.
        issue_b  = 1'b1;
        capt_a   = 1'b1;
        state_nx = ST_CAPT_B;
      end
      ST_CAPT_B: begin
        capt_b   = 1'b1;
        state_nx = ST_HOLD;
      end
      ST_HOLD: begin
        if (bus.Ready) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  assign clear_byp = (state_nx == ST_IDLE);

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      addr_a          <= '0;
      addr_b          <= '0;
      bus.RegReadAddr <= '0;
      bus.OperandA    <= '0;
      bus.OperandB    <= '0;
    end else begin
      if (latch_req) begin
        addr_a          <= addr_a_d;
        addr_b          <= addr_b_d;
        bus.RegReadAddr <= addr_a_d;
      end
      if (issue_a) bus.RegReadAddr <= addr_b;
      if (capt_a)  bus.OperandA    <= capt_a_data;
      if (capt_b)  bus.OperandB    <= capt_b_data;
    end
  end

  operand_bypass_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_slot_a (
    .clk       (CLK),
    .rst_n     (Reset),
    .clear     (clear_byp),
    .snoop     (issue_a),
    .addr      (addr_a),
    .we        (bus.WriteEnable),
    .wa        (bus.WriteAddr),
    .wd        (bus.WriteData),
    .rd_data   (bus.RegReadData),
    .capt_data (capt_a_data)
  );

  operand_bypass_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_slot_b (
    .clk       (CLK),
    .rst_n     (Reset),
    .clear     (clear_byp),
    .snoop     (issue_b),
    .addr      (addr_b),
    .we        (bus.WriteEnable),
    .wa        (bus.WriteAddr),
    .wd        (bus.WriteData),
    .rd_data   (bus.RegReadData),
    .capt_data (capt_b_data)
  );

  assign bus.Valid     = (state == ST_HOLD);
  assign bus.Busy      = (state != ST_IDLE);
  assign bus.state_dbg = state;

endmodule

// File: tb/tb_register_file_read_sequencer.sv
// Directed bench for the operand-fetch sequencer with a behavioural register file
// (synchronous read, old data on read-during-write).
module tb_register_file_read_sequencer;
  import register_file_read_sequencer_pkg::*;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic Reset = 1'b0;
  always #5 CLK = ~CLK;

  register_file_read_sequencer_if bus ();

  register_file_read_sequencer dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus)
  );

  logic [15:0] rf [16];
  always @(posedge CLK) begin
    bus.RegReadData <= rf[bus.RegReadAddr];
    if (bus.WriteEnable) rf[bus.WriteAddr] <= bus.WriteData;
  end

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic rf_write(input logic [3:0] a, input logic [15:0] d);
    bus.WriteEnable = 1'b1;
    bus.WriteAddr   = a;
    bus.WriteData   = d;
    tick();
    bus.WriteEnable = 1'b0;
  endtask

  task automatic start_req(input logic [7:0] ir, input logic rfra);
    bus.Start               = 1'b1;
    bus.InstructionRegister = ir;
    bus.RFRA                = rfra;
    tick();
    bus.Start = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output logic ok);
    int n;
    n = 0;
    while (bus.Valid !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    ok = (bus.Valid === 1'b1);
  endtask

  task automatic release_hold();
    bus.Ready = 1'b1;
    tick();
    bus.Ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    Reset = 1'b0;
    tick();
    tick();
    checks++;
    if (bus.Valid !== 1'b0 || bus.Busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: valid=%b busy=%b expected 0 0", bus.Valid, bus.Busy);
    end
    checks++;
    if (bus.OperandA !== 16'h0 || bus.OperandB !== 16'h0 || bus.RegReadAddr !== 4'h0) begin
      errors++;
      $display("FAIL reset_regs: a=%h b=%h addr=%h expected 0", bus.OperandA, bus.OperandB, bus.RegReadAddr);
    end
    checks++;
    if (bus.state_dbg !== ST_IDLE) begin
      errors++;
      $display("FAIL reset_state: got %0d expected %0d", bus.state_dbg, ST_IDLE);
    end
    Reset = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [31:0] exp;
    exp_q.push_back({16'h1234, 16'hABCD});
    start_req(8'h35, 1'b0);
    checks++;
    if (bus.RegReadAddr !== 4'h3 || bus.Busy !== 1'b1 || bus.Valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_issue_a: addr=%h busy=%b valid=%b expected 3 1 0", bus.RegReadAddr, bus.Busy, bus.Valid);
    end
    tick();
    checks++;
    if (bus.RegReadAddr !== 4'h5) begin
      errors++;
      $display("FAIL basic_issue_b: addr=%h expected 5", bus.RegReadAddr);
    end
    tick();
    checks++;
    if (bus.Valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_early_valid: valid=%b expected 0", bus.Valid);
    end
    tick();
    checks++;
    if (bus.Valid !== 1'b1) begin
      errors++;
      $display("FAIL basic_latency: valid=%b expected 1 four cycles after start", bus.Valid);
    end
    exp = exp_q.pop_front();
    checks++;
    if ({bus.OperandA, bus.OperandB} !== exp) begin
      errors++;
      $display("FAIL basic_operands: got %h %h expected %h %h", bus.OperandA, bus.OperandB, exp[31:16], exp[15:0]);
    end
    release_hold();
    checks++;
    if (bus.Valid !== 1'b0 || bus.Busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_accept: valid=%b busy=%b expected 0 0", bus.Valid, bus.Busy);
    end
  endtask

  task automatic test_sp_select();
    logic [31:0] exp;
    exp_q.push_back({16'h2222, 16'h0F0F});
    bus.Ready = 1'b1;
    start_req(8'h27, 1'b1);
    tick();
    checks++;
    if (bus.RegReadAddr !== 4'hD) begin
      errors++;
      $display("FAIL sp_addr: addr=%h expected d", bus.RegReadAddr);
    end
    tick();
    checks++;
    if (bus.Valid !== 1'b0 || bus.state_dbg !== ST_CAPT_B) begin
      errors++;
      $display("FAIL sp_ready_early: valid=%b state=%0d expected 0 %0d", bus.Valid, bus.state_dbg, ST_CAPT_B);
    end
    tick();
    exp = exp_q.pop_front();
    checks++;
    if (bus.Valid !== 1'b1 || {bus.OperandA, bus.OperandB} !== exp) begin
      errors++;
      $display("FAIL sp_operands: valid=%b got %h %h expected 1 %h %h", bus.Valid, bus.OperandA, bus.OperandB, exp[31:16], exp[15:0]);
    end
    tick();
    bus.Ready = 1'b0;
    checks++;
    if (bus.Valid !== 1'b0 || bus.Busy !== 1'b0) begin
      errors++;
      $display("FAIL sp_accept: valid=%b busy=%b expected 0 0", bus.Valid, bus.Busy);
    end
  endtask

  task automatic test_forwarding();
    logic [31:0] exp;
    exp_q.push_back({16'h5555, 16'h7777});
    start_req(8'h35, 1'b0);
    bus.WriteEnable = 1'b1;
    bus.WriteAddr   = 4'h3;
    bus.WriteData   = 16'h5555;
    tick();
    bus.WriteAddr   = 4'h5;
    bus.WriteData   = 16'h7777;
    tick();
    bus.WriteEnable = 1'b0;
    tick();
    exp = exp_q.pop_front();
    checks++;
    if (bus.Valid !== 1'b1 || {bus.OperandA, bus.OperandB} !== exp) begin
      errors++;
      $display("FAIL fwd_operands: valid=%b got %h %h expected 1 %h %h", bus.Valid, bus.OperandA, bus.OperandB, exp[31:16], exp[15:0]);
    end
    release_hold();
  endtask

  task automatic test_late_write();
    logic [31:0] exp;
    rf_write(4'h3, 16'h1234);
    exp_q.push_back({16'h1234, 16'h7777});
    start_req(8'h35, 1'b0);
    tick();
    tick();
    bus.WriteEnable = 1'b1;
    bus.WriteAddr   = 4'h3;
    bus.WriteData   = 16'h5555;
    tick();
    bus.WriteEnable = 1'b0;
    exp = exp_q.pop_front();
    checks++;
    if (bus.Valid !== 1'b1 || {bus.OperandA, bus.OperandB} !== exp) begin
      errors++;
      $display("FAIL late_operands: valid=%b got %h %h expected 1 %h %h", bus.Valid, bus.OperandA, bus.OperandB, exp[31:16], exp[15:0]);
    end
    repeat (3) tick();
    checks++;
    if (bus.OperandA !== 16'h1234) begin
      errors++;
      $display("FAIL late_hold_stable: a=%h expected 1234", bus.OperandA);
    end
    release_hold();
  endtask

  task automatic test_same_addr();
    logic [31:0] exp;
    logic ok;
    exp_q.push_back({16'h5555, 16'h9999});
    start_req(8'h33, 1'b0);
    tick();
    checks++;
    if (bus.RegReadAddr !== 4'h3) begin
      errors++;
      $display("FAIL same_issue_b_addr: addr=%h expected 3", bus.RegReadAddr);
    end
    bus.WriteEnable = 1'b1;
    bus.WriteAddr   = 4'h3;
    bus.WriteData   = 16'h9999;
    tick();
    bus.WriteEnable = 1'b0;
    wait_valid(4, ok);
    exp = exp_q.pop_front();
    checks++;
    if (ok !== 1'b1 || {bus.OperandA, bus.OperandB} !== exp) begin
      errors++;
      $display("FAIL same_operands: valid=%b got %h %h expected 1 %h %h", ok, bus.OperandA, bus.OperandB, exp[31:16], exp[15:0]);
    end
    release_hold();
  endtask

  task automatic test_back_pressure();
    logic [31:0] exp;
    logic ok;
    exp_q.push_back({16'h9999, 16'h7777});
    start_req(8'h35, 1'b0);
    wait_valid(6, ok);
    checks++;
    if (ok !== 1'b1) begin
      errors++;
      $display("FAIL bp_valid_timeout: valid=%b expected 1", ok);
    end
    exp = exp_q.pop_front();
    for (int i = 0; i < 10; i++) begin
      bus.Start = (i == 3);
      bus.InstructionRegister = 8'h27;
      bus.RFRA = 1'b1;
      checks++;
      if (bus.Valid !== 1'b1 || {bus.OperandA, bus.OperandB} !== exp) begin
        errors++;
        $display("FAIL bp_hold_%0d: valid=%b got %h %h expected 1 %h %h", i, bus.Valid, bus.OperandA, bus.OperandB, exp[31:16], exp[15:0]);
      end
      tick();
    end
    bus.Ready = 1'b1;
    bus.Start = 1'b1;
    tick();
    bus.Ready = 1'b0;
    bus.Start = 1'b0;
    checks++;
    if (bus.Valid !== 1'b0 || bus.Busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_accept: valid=%b busy=%b expected 0 0", bus.Valid, bus.Busy);
    end
    tick();
    checks++;
    if (bus.Busy !== 1'b0 || bus.state_dbg !== ST_IDLE) begin
      errors++;
      $display("FAIL bp_start_not_queued: busy=%b state=%0d expected 0 %0d", bus.Busy, bus.state_dbg, ST_IDLE);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] exp;
    logic ok;
    start_req(8'h35, 1'b0);
    tick();
    Reset = 1'b0;
    tick();
    Reset = 1'b1;
    checks++;
    if (bus.state_dbg !== ST_IDLE || bus.Valid !== 1'b0 || bus.Busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_state: state=%0d valid=%b busy=%b expected %0d 0 0", bus.state_dbg, bus.Valid, bus.Busy, ST_IDLE);
    end
    checks++;
    if (bus.OperandA !== 16'h0 || bus.OperandB !== 16'h0) begin
      errors++;
      $display("FAIL mid_reset_operands: a=%h b=%h expected 0 0", bus.OperandA, bus.OperandB);
    end
    tick();
    exp_q.push_back({16'h2222, 16'h1111});
    start_req(8'h27, 1'b0);
    wait_valid(6, ok);
    exp = exp_q.pop_front();
    checks++;
    if (ok !== 1'b1 || {bus.OperandA, bus.OperandB} !== exp) begin
      errors++;
      $display("FAIL mid_refetch: valid=%b got %h %h expected 1 %h %h", ok, bus.OperandA, bus.OperandB, exp[31:16], exp[15:0]);
    end
    release_hold();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    bus.Start               = 1'b0;
    bus.RFRA                = 1'b0;
    bus.InstructionRegister = 8'h00;
    bus.WriteEnable         = 1'b0;
    bus.WriteAddr           = 4'h0;
    bus.WriteData           = 16'h0;
    bus.Ready               = 1'b0;

    test_reset();
    rf_write(4'h3, 16'h1234);
    rf_write(4'h5, 16'hABCD);
    rf_write(4'h2, 16'h2222);
    rf_write(4'h7, 16'h1111);
    rf_write(4'hD, 16'h0F0F);
    tick();

    test_basic();
    test_sp_select();
    test_forwarding();
    test_late_write();
    test_same_addr();
    test_back_pressure();
    test_reset_mid();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
